// File: rtl/picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_mem_arbiter
// Brief    : Two-requester arbiter for one picorv32 native memory port, with
//            optional round-robin priority and a bounded-wait abort.
// Revision : 1.0 - initial release
// ============================================================================
module picorv32_mem_arbiter #(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic [7:0]  timeout_cnt
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_GRANT0 = 2'd1;
    localparam logic [1:0] c_ST_GRANT1 = 2'd2;

    logic [1:0] r_state;
    logic       r_prio;
    logic [7:0] r_timeout_cnt;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_granted;
    logic       w_timeout;
    logic       w_done;
    logic       w_pick1;

    assign w_gnt0    = (r_state == c_ST_GRANT0);
    assign w_gnt1    = (r_state == c_ST_GRANT1);
    assign w_granted = w_gnt0 | w_gnt1;
    // A slave response in the final wait cycle beats the abort.
    assign w_done    = w_granted & (s_ready | w_timeout);

    always_comb begin
        w_pick1 = 1'b0;
        if (m1_valid) begin
            if (!m0_valid) begin
                w_pick1 = 1'b1;
            end else if (ROUND_ROBIN != 0) begin
                w_pick1 = r_prio;
            end
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int c_WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

            logic [c_WAIT_W-1:0] r_wait;

            always_ff @(posedge clk) begin
                if (reset || !w_granted) begin
                    r_wait <= '0;
                end else if (!s_ready) begin
                    r_wait <= r_wait + 1'b1;
                end
            end

            assign w_timeout = w_granted & ~s_ready & (r_wait == c_WAIT_LAST);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_prio        <= 1'b0;
            r_timeout_cnt <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        r_state <= w_pick1 ? c_ST_GRANT1 : c_ST_GRANT0;
                    end
                end
                c_ST_GRANT0, c_ST_GRANT1: begin
                    if (w_done) begin
                        r_state <= c_ST_IDLE;
                        // Hand priority to the requester that did not just finish.
                        if (ROUND_ROBIN != 0) begin
                            r_prio <= w_gnt0;
                        end
                    end
                    if (w_timeout && (r_timeout_cnt != 8'hFF)) begin
                        r_timeout_cnt <= r_timeout_cnt + 8'd1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign s_valid = w_granted;
    assign s_instr = (w_gnt0 & m0_instr) | (w_gnt1 & m1_instr);
    assign s_addr  = w_gnt0 ? m0_addr  : (w_gnt1 ? m1_addr  : 32'd0);
    assign s_wdata = w_gnt0 ? m0_wdata : (w_gnt1 ? m1_wdata : 32'd0);
    assign s_wstrb = w_gnt0 ? m0_wstrb : (w_gnt1 ? m1_wstrb : 4'd0);

    // Return path is combinational so the requester sees the slave's cycle.
    assign m0_ready = w_gnt0 & w_done;
    assign m1_ready = w_gnt1 & w_done;
    assign m0_err   = w_gnt0 & w_timeout;
    assign m1_err   = w_gnt1 & w_timeout;
    assign m0_rdata = (w_gnt0 & s_ready) ? s_rdata : 32'd0;
    assign m1_rdata = (w_gnt1 & s_ready) ? s_rdata : 32'd0;

    assign grant       = {w_gnt1, w_gnt0};
    assign timeout_cnt = r_timeout_cnt;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_picorv32_mem_arbiter
// Brief    : Directed self-checking bench for picorv32_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_picorv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        rr_m0_ready, rr_m0_err, rr_m1_ready, rr_m1_err;
    logic [31:0] rr_m0_rdata, rr_m1_rdata;
    logic        rr_s_valid, rr_s_instr;
    logic [31:0] rr_s_addr, rr_s_wdata;
    logic [3:0]  rr_s_wstrb;
    logic [1:0]  rr_grant;
    logic [7:0]  rr_timeout_cnt;

    logic        fp_m0_ready, fp_m0_err, fp_m1_ready, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_s_valid, fp_s_instr;
    logic [31:0] fp_s_addr, fp_s_wdata;
    logic [3:0]  fp_s_wstrb;
    logic [1:0]  fp_grant;
    logic [7:0]  fp_timeout_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    picorv32_mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(rr_m0_ready), .m0_rdata(rr_m0_rdata), .m0_err(rr_m0_err),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(rr_m1_ready), .m1_rdata(rr_m1_rdata), .m1_err(rr_m1_err),
        .s_valid(rr_s_valid), .s_instr(rr_s_instr), .s_addr(rr_s_addr), .s_wdata(rr_s_wdata),
        .s_wstrb(rr_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(rr_grant), .timeout_cnt(rr_timeout_cnt)
    );

    picorv32_mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
        .s_valid(fp_s_valid), .s_instr(fp_s_instr), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
        .s_wstrb(fp_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(fp_grant), .timeout_cnt(fp_timeout_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [1:0] exp_rr [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [1:0] exp_fp [5] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};

    initial begin
        int err_pulses;
        logic seen_ready;

        // Reset state and a single m0 read with a 3-cycle slave.
        do_reset();
        #1;
        check("rst_grant", 32'(rr_grant), 32'd0);
        check("rst_s_valid", 32'(rr_s_valid), 32'd0);
        check("rst_tocnt", 32'(rr_timeout_cnt), 32'd0);
        check("rst_m0_ready", 32'(rr_m0_ready), 32'd0);
        check("rst_s_addr", rr_s_addr, 32'd0);
        m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h0000_0100;
        #1;
        check("rd_latency", 32'(rr_s_valid), 32'd0);
        step(); #1;
        check("rd_s_valid", 32'(rr_s_valid), 32'd1);
        check("rd_grant", 32'(rr_grant), 32'd1);
        check("rd_s_addr", rr_s_addr, 32'h0000_0100);
        check("rd_s_instr", 32'(rr_s_instr), 32'd1);
        step();
        step();
        s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        check("rd_m0_ready", 32'(rr_m0_ready), 32'd1);
        check("rd_m0_rdata", rr_m0_rdata, 32'hDEAD_BEEF);
        check("rd_m0_err", 32'(rr_m0_err), 32'd0);
        check("rd_m1_ready", 32'(rr_m1_ready), 32'd0);
        step();
        m0_valid = 1'b0; m0_instr = 1'b0;
        #1;
        check("idle_grant", 32'(rr_grant), 32'd0);
        check("idle_ignore", 32'({rr_m1_ready, rr_m0_ready}), 32'd0);
        s_ready = 1'b0;

        // Round-robin alternation with both requesters always pending.
        do_reset();
        m0_valid = 1'b1; m1_valid = 1'b1;
        #1;
        check("rr_start", 32'(rr_grant), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            s_ready = (exp_rr[i] != 2'b00);
            #1;
            check($sformatf("rr_grant%0d", i), 32'(rr_grant), 32'(exp_rr[i]));
            check($sformatf("rr_ready%0d", i), 32'({rr_m1_ready, rr_m0_ready}), 32'(exp_rr[i]));
        end
        step();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

        // Fixed priority: m0 keeps winning until it goes quiet.
        do_reset();
        m0_valid = 1'b1; m1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            s_ready = (exp_fp[i] != 2'b00);
            #1;
            check($sformatf("fp_grant%0d", i), 32'(fp_grant), 32'(exp_fp[i]));
        end
        step();
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        check("fp_idle", 32'(fp_grant), 32'd0);
        step();
        s_ready = 1'b1;
        #1;
        check("fp_m1_grant", 32'(fp_grant), 32'd2);
        check("fp_m1_ready", 32'(fp_m1_ready), 32'd1);
        step();
        m1_valid = 1'b0; s_ready = 1'b0;

        // Timeout abort on m1 after 8 granted cycles.
        do_reset();
        m1_valid = 1'b1; m1_addr = 32'h0000_0040; s_rdata = 32'h1234_5678;
        for (int g = 1; g <= 8; g++) begin
            step(); #1;
            check($sformatf("to_ready_c%0d", g), 32'(rr_m1_ready), (g == 8) ? 32'd1 : 32'd0);
        end
        check("to_err", 32'(rr_m1_err), 32'd1);
        check("to_rdata", rr_m1_rdata, 32'd0);
        check("to_m0_ready", 32'(rr_m0_ready), 32'd0);
        step();
        m1_valid = 1'b0;
        #1;
        check("to_s_valid", 32'(rr_s_valid), 32'd0);
        check("to_cnt1", 32'(rr_timeout_cnt), 32'd1);

        // Slave answers in the final wait cycle: normal completion.
        m1_valid = 1'b1;
        for (int g = 1; g <= 8; g++) begin
            step();
            s_ready = (g == 8); s_rdata = 32'hCAFE_F00D;
            #1;
        end
        check("late_ready", 32'(rr_m1_ready), 32'd1);
        check("late_err", 32'(rr_m1_err), 32'd0);
        check("late_rdata", rr_m1_rdata, 32'hCAFE_F00D);
        step();
        m1_valid = 1'b0; s_ready = 1'b0;
        #1;
        check("late_cnt", 32'(rr_timeout_cnt), 32'd1);

        // 300 further timeouts saturate the counter at 255.
        err_pulses = 0;
        m0_valid = 1'b1;
        for (int c = 0; c < 300 * 9; c++) begin
            step(); #1;
            if (rr_m0_err) err_pulses++;
        end
        m0_valid = 1'b0;
        step(); step(); #1;
        check("sat_pulses", 32'(err_pulses), 32'd300);
        check("sat_cnt", 32'(rr_timeout_cnt), 32'd255);

        // Reset two cycles into an m1 write drops it silently.
        do_reset();
        m1_valid = 1'b1; m1_addr = 32'h0000_2000; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'hF;
        step(); #1;
        check("wr_grant", 32'(rr_grant), 32'd2);
        check("wr_s_wstrb", 32'(rr_s_wstrb), 32'hF);
        check("wr_s_wdata", rr_s_wdata, 32'hA5A5_A5A5);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; m1_valid = 1'b0; s_ready = 1'b1;
        #1;
        check("mid_s_valid", 32'(rr_s_valid), 32'd0);
        check("mid_grant", 32'(rr_grant), 32'd0);
        seen_ready = rr_m1_ready;
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            seen_ready = seen_ready | rr_m1_ready;
        end
        check("mid_no_ready", 32'(seen_ready), 32'd0);
        s_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
